// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   state_t            : loader FSM state encoding
//   DEF_SYNC_BYTE      : default frame start marker
//   DEF_MAX_WORDS      : default instruction memory capacity in words
//   DEF_TIMEOUT_CYCLES : default inter-byte gap limit inside a frame
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
    localparam int unsigned DEF_MAX_WORDS      = 256;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : drops any partially assembled word
//   byte_valid    : byte strobe
//   byte_in       : byte data
//   word          : {b3,b2,b1,b0}, meaningful while word_valid is high
//   word_valid    : high on the strobe that carries the 4th byte
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] sr_q;
    logic [1:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (byte_valid) begin
            sr_q  <= {byte_in, sr_q[23:8]};
            cnt_q <= cnt_q + 2'd1;
        end
    end

    // The 4th byte is combined straight from the input, so the word is
    // available on the same cycle as its last strobe.
    assign word       = {byte_in, sr_q};
    assign word_valid = byte_valid && (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: framed byte stream -> instruction memory writes.
//   clk, Reset          : clock, synchronous active-high reset
//   byte_in, byte_valid : received byte stream, one strobe per byte
//   WE_mem, WD_mem, WA_mem : instruction memory write port (byte address)
//   CpuReset            : holds the core in reset during load and error
//   busy                : high in LEN0, LEN1, DATA
//   done                : one-cycle pulse after a successful load
//   err                 : high while in ERROR
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS      = DEF_MAX_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        WE_mem,
    output logic [31:0] WD_mem,
    output logic [9:0]  WA_mem,
    output logic        CpuReset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [15:0] MAX_N    = 16'(MAX_WORDS);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [31:0] tmo_q;
    logic        we_q;
    logic [31:0] wd_q;
    logic [9:0]  wa_q;

    logic [15:0] len_n;
    logic        frame_start;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic        pk_word_valid;

    assign len_n       = {byte_in, len_lo_q};
    assign frame_start = byte_valid && (byte_in == SYNC_BYTE) &&
                         (state_q == S_IDLE || state_q == S_ERROR);
    // Bytes beyond the last word of the frame are not packed.
    assign pk_valid    = byte_valid && (state_q == S_DATA) && (idx_q != len_q);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (Reset),
        .clear      (frame_start),
        .byte_valid (pk_valid),
        .byte_in    (byte_in),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            we_q     <= 1'b0;
            wd_q     <= '0;
            wa_q     <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_ERROR: begin
                    if (frame_start) begin
                        state_q <= S_LEN0;
                        tmo_q   <= '0;
                    end
                end
                S_LEN0: begin
                    if (byte_valid) begin
                        len_lo_q <= byte_in;
                        tmo_q    <= '0;
                        state_q  <= S_LEN1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_LEN1: begin
                    if (byte_valid) begin
                        len_q <= len_n;
                        idx_q <= '0;
                        tmo_q <= '0;
                        if (len_n == 16'd0 || len_n > MAX_N)
                            state_q <= S_ERROR;
                        else
                            state_q <= S_DATA;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_DATA: begin
                    // Completion is seen one cycle after the last write so
                    // that done trails WE_mem by a cycle.
                    if (idx_q == len_q) begin
                        state_q <= S_DONE;
                    end else if (byte_valid) begin
                        tmo_q <= '0;
                        if (pk_word_valid) begin
                            we_q  <= 1'b1;
                            wd_q  <= pk_word;
                            wa_q  <= {idx_q[7:0], 2'b00};
                            idx_q <= idx_q + 16'd1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign WE_mem   = we_q;
    assign WD_mem   = wd_q;
    assign WA_mem   = wa_q;
    assign busy     = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
    assign err      = (state_q == S_ERROR);
    assign done     = (state_q == S_DONE);
    assign CpuReset = busy || err;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

    logic        clk;
    logic        Reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        WE_mem;
    logic [31:0] WD_mem;
    logic [9:0]  WA_mem;
    logic        CpuReset;
    logic        busy;
    logic        done;
    logic        err;

    int unsigned checks;
    int unsigned errors;
    int unsigned we_cnt;
    int unsigned base;
    logic [31:0] last_wd;
    logic [9:0]  last_wa;
    bit          seen;

    program_loader #(
        .MAX_WORDS      (256),
        .TIMEOUT_CYCLES (40)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .WE_mem     (WE_mem),
        .WD_mem     (WD_mem),
        .WA_mem     (WA_mem),
        .CpuReset   (CpuReset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-pulse log, sampled on the edge so negedge reads are race-free.
    always @(posedge clk) begin
        if (WE_mem) begin
            we_cnt  <= we_cnt + 1;
            last_wd <= WD_mem;
            last_wa <= WA_mem;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one strobe from a negedge; consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},   32'(WE_mem),   32'd0);
        chk({tag, "_wd"},   WD_mem,        32'd0);
        chk({tag, "_wa"},   32'(WA_mem),   32'd0);
        chk({tag, "_cpur"}, 32'(CpuReset), 32'd0);
        chk({tag, "_busy"}, 32'(busy),     32'd0);
        chk({tag, "_done"}, 32'(done),     32'd0);
        chk({tag, "_err"},  32'(err),      32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        we_cnt     = 0;
        last_wd    = '0;
        last_wa    = '0;
        Reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        idle(3);
        chk_all_zero("reset");
        Reset = 1'b0;
        idle(1);

        // Two-word load
        send(8'hA5);
        chk("sync_cpur", 32'(CpuReset), 32'd1);
        chk("sync_busy", 32'(busy), 32'd1);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        chk("w0_we", 32'(WE_mem), 32'd1);
        chk("w0_wa", 32'(WA_mem), 32'd0);
        chk("w0_wd", WD_mem, 32'h0000_0013);
        chk("w0_cpur", 32'(CpuReset), 32'd1);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        chk("w1_we", 32'(WE_mem), 32'd1);
        chk("w1_wa", 32'(WA_mem), 32'd4);
        chk("w1_wd", WD_mem, 32'h0010_0093);
        chk("w1_done_early", 32'(done), 32'd0);
        chk("w1_cpur", 32'(CpuReset), 32'd1);
        idle(1);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_cpur", 32'(CpuReset), 32'd0);
        chk("done_we", 32'(WE_mem), 32'd0);
        idle(1);
        chk("after_done", 32'(done), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
        chk("load_writes", we_cnt, 32'd2);

        // Zero length, then recovery
        base = we_cnt;
        send(8'hA5); send(8'h00); send(8'h00);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_cpur", 32'(CpuReset), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        idle(2);
        chk("len0_nowrite", we_cnt, base);
        send(8'hA5);
        chk("restart_err", 32'(err), 32'd0);
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        idle(3);
        chk("reload_writes", we_cnt, base + 2);
        chk("reload_wa", 32'(last_wa), 32'd4);
        chk("reload_wd", last_wd, 32'h0010_0093);

        // Oversize length 257
        base = we_cnt;
        send(8'hA5); send(8'h01); send(8'h01);
        chk("len257_err", 32'(err), 32'd1);
        idle(2);
        chk("len257_nowrite", we_cnt, base);

        // Exactly MAX_WORDS is accepted
        send(8'hA5); send(8'h00); send(8'h01);
        chk("len256_err", 32'(err), 32'd0);
        chk("len256_busy", 32'(busy), 32'd1);
        Reset = 1'b1;
        idle(1);
        chk("len256_rst_cpur", 32'(CpuReset), 32'd0);
        Reset = 1'b0;

        // Inter-byte timeout
        base = we_cnt;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h13); send(8'h00);
        idle(30);
        chk("tmo_early_err", 32'(err), 32'd0);
        chk("tmo_early_busy", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            idle(1);
            if (err) seen = 1'b1;
        end
        chk("tmo_err", 32'(seen), 32'd1);
        chk("tmo_cpur", 32'(CpuReset), 32'd1);
        chk("tmo_nowrite", we_cnt, base);

        // Reset mid-frame after 6 of 8 data bytes
        base = we_cnt;
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        Reset = 1'b1;
        idle(1);
        chk("midrst_cpur", 32'(CpuReset), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_we", 32'(WE_mem), 32'd0);
        chk("midrst_wa", 32'(WA_mem), 32'd0);
        Reset = 1'b0;
        idle(2);
        chk("midrst_writes", we_cnt, base + 1);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h77); send(8'h88); send(8'h99); send(8'hAA);
        chk("postrst_we", 32'(WE_mem), 32'd1);
        chk("postrst_wa", 32'(WA_mem), 32'd0);
        chk("postrst_wd", WD_mem, 32'hAA99_8877);
        idle(3);

        // Stray bytes before sync, then back-to-back data
        send(8'h00); idle(1);
        send(8'hFF); idle(1);
        send(8'h13); idle(1);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_cpur", 32'(CpuReset), 32'd0);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("b2b_we", 32'(WE_mem), 32'd1);
        chk("b2b_wa", 32'(WA_mem), 32'd0);
        chk("b2b_wd", WD_mem, 32'hDEAD_BEEF);
        idle(3);

        // Sync value inside the data payload is plain data
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        chk("syncdata_we", 32'(WE_mem), 32'd1);
        chk("syncdata_wd", WD_mem, 32'h0000_00A5);
        idle(1);
        chk("syncdata_done", 32'(done), 32'd1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
